// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and encodings for the multi-cycle sequencer: state encoding,
// latched Control flags, aluSrcB select codes and the ALU add opcode.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } seq_state_e;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_CONST2 = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;

  localparam logic [2:0] ALU_OP_ADD  = 3'b000;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] branch_type;
  } ctrl_flags_t;

  // States in which the sequencer waits on memReady and the timeout counter runs.
  function automatic logic is_mem_wait_state(input seq_state_e s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Bundle of Control flags, memory handshake and datapath controls between the
// sequencer (slave side) and the surrounding core (master side).
interface multicycle_sequencer_if #(
  parameter int CNT_W = 16
);

  logic             input_branch;
  logic             input_memRead;
  logic             input_memWrite;
  logic             input_regWrite;
  logic             input_ALUSrc;
  logic [2:0]       input_ALUOp;
  logic [1:0]       input_branchType;
  logic             input_memReady;

  logic             output_memReadEn;
  logic             output_memWriteEn;
  logic             output_IorD;
  logic             output_irWrite;
  logic             output_pcWrite;
  logic             output_pcWriteCond;
  logic [1:0]       output_branchTypeQ;
  logic             output_regLatch;
  logic             output_aluSrcA;
  logic [1:0]       output_aluSrcB;
  logic [2:0]       output_ALUOpQ;
  logic             output_regWriteEn;
  logic             output_memToReg;
  logic             output_fault;
  logic [CNT_W-1:0] output_retired;

  modport master (
    output input_branch, input_memRead, input_memWrite, input_regWrite,
           input_ALUSrc, input_ALUOp, input_branchType, input_memReady,
    input  output_memReadEn, output_memWriteEn, output_IorD, output_irWrite,
           output_pcWrite, output_pcWriteCond, output_branchTypeQ, output_regLatch,
           output_aluSrcA, output_aluSrcB, output_ALUOpQ, output_regWriteEn,
           output_memToReg, output_fault, output_retired
  );

  modport slave (
    input  input_branch, input_memRead, input_memWrite, input_regWrite,
           input_ALUSrc, input_ALUOp, input_branchType, input_memReady,
    output output_memReadEn, output_memWriteEn, output_IorD, output_irWrite,
           output_pcWrite, output_pcWriteCond, output_branchTypeQ, output_regLatch,
           output_aluSrcA, output_aluSrcB, output_ALUOpQ, output_regWriteEn,
           output_memToReg, output_fault, output_retired
  );

endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the 16-bit core.
// Latches Control flags once per instruction and emits Moore datapath controls.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic                 input_clk,
  input  logic                 input_reset_n,
  multicycle_sequencer_if.slave bus
);

  localparam int                WAIT_W    = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  seq_state_e        state_q, state_d;
  ctrl_flags_t       flags_q, flags_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              retire_s;

  logic       mem_read_en_s;
  logic       mem_write_en_s;
  logic       iord_s;
  logic       ir_write_s;
  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic [1:0] branch_type_s;
  logic       reg_latch_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [2:0] alu_op_s;
  logic       reg_write_en_s;
  logic       mem_to_reg_s;
  logic       fault_s;

  // State, latched flags, wait counter and retired counter registers.
  always_ff @(posedge input_clk or negedge input_reset_n) begin
    if (!input_reset_n) begin
      state_q   <= ST_IDLE;
      flags_q   <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, flag capture, memory-wait timeout and retirement decisions.
  always_comb begin
    state_d  = state_q;
    flags_d  = flags_q;
    wait_d   = wait_q;
    retire_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Ready on the limit cycle still counts as a completed access.
        if (bus.input_memReady) begin
          state_d = ST_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DECODE: begin
        flags_d = {bus.input_branch, bus.input_memRead, bus.input_memWrite,
                   bus.input_regWrite, bus.input_ALUSrc, bus.input_ALUOp,
                   bus.input_branchType};
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (flags_q.branch) begin
          state_d  = ST_FETCH;
          retire_s = 1'b1;
        end else if (flags_q.mem_read || flags_q.mem_write) begin
          state_d = ST_MEM;
        end else if (flags_q.reg_write) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d  = ST_FETCH;
          retire_s = 1'b1;
        end
      end
      ST_MEM: begin
        if (bus.input_memReady) begin
          if (flags_q.mem_read) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d  = ST_FETCH;
            retire_s = 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_WRITEBACK: begin
        state_d  = ST_FETCH;
        retire_s = 1'b1;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The counter restarts whenever a new wait state is entered.
    if ((state_d != state_q) || !is_mem_wait_state(state_q)) begin
      wait_d = '0;
    end else begin
      wait_d = wait_d;
    end

    if (retire_s) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // Moore datapath controls from state and latched flags (irWrite/pcWrite qualified by memReady).
  always_comb begin
    mem_read_en_s   = 1'b0;
    mem_write_en_s  = 1'b0;
    iord_s          = 1'b0;
    ir_write_s      = 1'b0;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    branch_type_s   = 2'b00;
    reg_latch_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = SRCB_B;
    alu_op_s        = ALU_OP_ADD;
    reg_write_en_s  = 1'b0;
    mem_to_reg_s    = 1'b0;
    fault_s         = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read_en_s = 1'b1;
        alu_src_b_s   = SRCB_CONST2;
        if (bus.input_memReady) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
        end else begin
          ir_write_s = 1'b0;
          pc_write_s = 1'b0;
        end
      end
      ST_DECODE: begin
        reg_latch_s = 1'b1;
      end
      ST_EXECUTE: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = flags_q.alu_src ? SRCB_IMM : SRCB_B;
        alu_op_s    = flags_q.alu_op;
        if (flags_q.branch) begin
          pc_write_cond_s = 1'b1;
          branch_type_s   = flags_q.branch_type;
        end else begin
          pc_write_cond_s = 1'b0;
          branch_type_s   = 2'b00;
        end
      end
      ST_MEM: begin
        iord_s         = 1'b1;
        mem_read_en_s  = flags_q.mem_read;
        mem_write_en_s = flags_q.mem_write & ~flags_q.mem_read;
      end
      ST_WRITEBACK: begin
        reg_write_en_s = 1'b1;
        mem_to_reg_s   = flags_q.mem_read;
      end
      ST_HALT: begin
        fault_s = 1'b1;
      end
      default: begin
        fault_s = 1'b0;
      end
    endcase
  end

  assign bus.output_memReadEn   = mem_read_en_s;
  assign bus.output_memWriteEn  = mem_write_en_s;
  assign bus.output_IorD        = iord_s;
  assign bus.output_irWrite     = ir_write_s;
  assign bus.output_pcWrite     = pc_write_s;
  assign bus.output_pcWriteCond = pc_write_cond_s;
  assign bus.output_branchTypeQ = branch_type_s;
  assign bus.output_regLatch    = reg_latch_s;
  assign bus.output_aluSrcA     = alu_src_a_s;
  assign bus.output_aluSrcB     = alu_src_b_s;
  assign bus.output_ALUOpQ      = alu_op_s;
  assign bus.output_regWriteEn  = reg_write_en_s;
  assign bus.output_memToReg    = mem_to_reg_s;
  assign bus.output_fault       = fault_s;
  assign bus.output_retired     = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction step-plan model checked every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_multicycle_sequencer;

  localparam int MAXW = 15;
  localparam int CW   = 8;

  localparam int S_I = 0, S_F = 1, S_D = 2, S_E = 3, S_M = 4, S_W = 5, S_H = 6;

  // Control word layout: {branch, memRead, memWrite, regWrite, ALUSrc, ALUOp[2:0], branchType[1:0]}
  localparam logic [9:0] RT  = 10'b0_0_0_1_0_010_00;
  localparam logic [9:0] LD  = 10'b0_1_0_1_1_000_00;
  localparam logic [9:0] BR  = 10'b1_0_0_1_0_001_01;
  localparam logic [9:0] ST  = 10'b0_0_1_0_1_000_00;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_sequencer_if #(.CNT_W(CW)) bus ();

  multicycle_sequencer #(.MEM_WAIT_MAX(MAXW), .CNT_W(CW)) dut (
    .input_clk     (clk),
    .input_reset_n (rst_n),
    .bus           (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: current step plus the remaining steps planned for this instruction.
  int         cur;
  int         plan[$];
  int         waitc;
  logic [CW-1:0] m_retired;
  logic       fb, fmr, fmw, frw, fas;
  logic [2:0] fop;
  logic [1:0] fbt;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cur = S_I;
    plan.delete();
    waitc = 0;
    m_retired = '0;
    {fb, fmr, fmw, frw, fas, fop, fbt} = 10'd0;
  endtask

  task automatic next_step();
    waitc = 0;
    if (plan.size() == 0) begin
      cur = S_F;
      m_retired = m_retired + 1'b1;
    end else begin
      cur = plan.pop_front();
    end
  endtask

  task automatic model_advance(input bit rdy, input logic [9:0] ctl);
    case (cur)
      S_I: begin cur = S_F; waitc = 0; end
      S_F: begin
        if (rdy) cur = S_D;
        else if (waitc == MAXW - 1) cur = S_H;
        else waitc++;
      end
      S_D: begin
        {fb, fmr, fmw, frw, fas, fop, fbt} = ctl;
        plan.delete();
        if (!fb) begin
          if (fmr || fmw) begin
            plan.push_back(S_M);
            if (fmr) plan.push_back(S_W);
          end else if (frw) begin
            plan.push_back(S_W);
          end
        end
        cur = S_E;
      end
      S_E, S_W: next_step();
      S_M: begin
        if (rdy) next_step();
        else if (waitc == MAXW - 1) cur = S_H;
        else waitc++;
      end
      default: ;
    endcase
  endtask

  function automatic logic [17:0] model_outs(input bit rdy);
    logic mre, mwe, iord, irw, pcw, pcwc, rl, asa, rwe, m2r, flt;
    logic [1:0] bt, asb;
    logic [2:0] op;
    {mre, mwe, iord, irw, pcw, pcwc, bt, rl, asa, asb, op, rwe, m2r, flt} = 18'd0;
    case (cur)
      S_F: begin mre = 1'b1; asb = 2'd1; irw = rdy; pcw = rdy; end
      S_D: rl = 1'b1;
      S_E: begin
        asa = 1'b1; asb = fas ? 2'd2 : 2'd0; op = fop;
        pcwc = fb; bt = fb ? fbt : 2'b00;
      end
      S_M: begin iord = 1'b1; mre = fmr; mwe = fmw && !fmr; end
      S_W: begin rwe = 1'b1; m2r = fmr; end
      S_H: flt = 1'b1;
      default: ;
    endcase
    return {mre, mwe, iord, irw, pcw, pcwc, bt, rl, asa, asb, op, rwe, m2r, flt};
  endfunction

  function automatic logic [17:0] dut_outs();
    return {bus.output_memReadEn, bus.output_memWriteEn, bus.output_IorD,
            bus.output_irWrite, bus.output_pcWrite, bus.output_pcWriteCond,
            bus.output_branchTypeQ, bus.output_regLatch, bus.output_aluSrcA,
            bus.output_aluSrcB, bus.output_ALUOpQ, bus.output_regWriteEn,
            bus.output_memToReg, bus.output_fault};
  endfunction

  function automatic logic [9:0] rctl();
    return 10'($urandom);
  endfunction

  // One clock cycle: drive at negedge, compare against the model, then advance the model.
  task automatic step(input bit rst, input bit rdy, input logic [9:0] ctl);
    @(negedge clk);
    rst_n = rst;
    bus.input_memReady = rdy;
    {bus.input_branch, bus.input_memRead, bus.input_memWrite, bus.input_regWrite,
     bus.input_ALUSrc, bus.input_ALUOp, bus.input_branchType} = ctl;
    if (!rst) model_reset();
    #2;
    check("outs", 32'(dut_outs()), 32'(model_outs(rdy)));
    check("retired", 32'(bus.output_retired), 32'(m_retired));
    if (rst) model_advance(rdy, ctl);
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    bus.input_memReady = 1'b0;
    {bus.input_branch, bus.input_memRead, bus.input_memWrite, bus.input_regWrite,
     bus.input_ALUSrc, bus.input_ALUOp, bus.input_branchType} = 10'd0;
    model_reset();

    // Reset: everything zero regardless of inputs.
    step(1'b0, 1'b0, 10'd0);
    step(1'b0, 1'b1, rctl());
    check("rst_zero", {6'd0, dut_outs(), bus.output_retired}, 32'd0);

    // R-type ALU op with 0-wait memory: F, D, E, WB.
    step(1'b1, 1'b1, RT);   // IDLE
    n = 0;
    repeat (4) begin
      step(1'b1, 1'b1, RT);
      n += int'(bus.output_regWriteEn);
      if (bus.output_regWriteEn) check("t1_memToReg", 32'(bus.output_memToReg), 32'd0);
    end
    check("t1_wb_pulses", n, 32'd1);
    step(1'b1, 1'b1, LD);   // next FETCH, ready
    check("t1_retired", 32'(bus.output_retired), 32'd1);

    // Load with three not-ready cycles in MEM.
    step(1'b1, 1'b1, LD);   // DECODE
    step(1'b1, 1'b1, rctl()); // EXECUTE, later control changes ignored
    n = 0;
    repeat (3) begin
      step(1'b1, 1'b0, rctl());
      n += int'(bus.output_memReadEn && bus.output_IorD);
    end
    step(1'b1, 1'b1, rctl());
    n += int'(bus.output_memReadEn && bus.output_IorD);
    check("t2_mem_cycles", n, 32'd4);
    step(1'b1, 1'b1, rctl());
    check("t2_wb", {bus.output_regWriteEn, bus.output_memToReg}, 32'd3);

    // Branch: pcWriteCond with latched branch type, then FETCH.
    step(1'b1, 1'b1, BR);   // FETCH
    step(1'b1, 1'b1, BR);   // DECODE
    step(1'b1, 1'b1, rctl()); // EXECUTE
    check("t3_exec", {bus.output_pcWriteCond, bus.output_branchTypeQ,
                      bus.output_regWriteEn, bus.output_memWriteEn}, 32'h14);
    step(1'b1, 1'b0, rctl()); // FETCH, not ready
    check("t3_fetch", {bus.output_memReadEn, bus.output_IorD}, 32'd2);

    // Memory never ready in FETCH: HALT after MAXW cycles.
    n = 1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, rctl());
      if (bus.output_fault) break;
      n += int'(bus.output_memReadEn);
    end
    check("t4_wait_cycles", n, 32'(MAXW));
    repeat (4) step(1'b1, 1'($urandom), rctl());
    check("t4_halt", 32'(dut_outs()), 32'd1);

    // Reset mid-MEM store after one retired instruction.
    step(1'b0, 1'b0, rctl());
    step(1'b1, 1'b1, RT);   // IDLE
    repeat (4) step(1'b1, 1'b1, RT);
    step(1'b1, 1'b1, ST);   // FETCH
    step(1'b1, 1'b1, ST);   // DECODE
    step(1'b1, 1'b1, ST);   // EXECUTE
    step(1'b1, 1'b0, ST);   // MEM
    check("t5_mem_store", {bus.output_memWriteEn, bus.output_memReadEn, bus.output_IorD}, 32'h5);
    check("t5_ret_before", 32'(bus.output_retired), 32'd1);
    step(1'b0, 1'b0, ST);
    check("t5_rst_zero", {6'd0, dut_outs(), bus.output_retired}, 32'd0);
    step(1'b1, 1'b0, ST);   // IDLE
    check("t5_idle", 32'(dut_outs()), 32'd0);
    step(1'b1, 1'b0, ST);   // FETCH
    check("t5_fetch", {bus.output_memReadEn, bus.output_retired}, {23'd0, 1'b1, 8'd0});

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 900; i++) begin
      step(($urandom_range(0, 249) != 0), ($urandom_range(0, 3) != 0), rctl());
    end

    // Retired counter wrap with one-cycle (non-writing) ops.
    step(1'b0, 1'b1, 10'd0);
    step(1'b1, 1'b1, 10'd0); // IDLE
    repeat (766) step(1'b1, 1'b1, rctl() & 10'h01F);
    check("t6_full", 32'(bus.output_retired), 32'hFF);
    repeat (3) step(1'b1, 1'b1, rctl() & 10'h01F);
    check("t6_wrap", 32'(bus.output_retired), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
